pipo_share_ctrl: RTL and testbench
==================================

# pipo_share_ctrl

Round-robin controller that shares a single W-bit parallel-in/parallel-out holding register between four requesters. Each requester presents a data word with a request. The block grants one requester per load, captures its word into the register, and holds it with a valid flag until the downstream consumer accepts it. It sits between the producer-side requesters and the shared register consumer.

## Interface
- W, default 4: data width of each requester word and of the held register.
- N: fixed at 4 requesters; not a parameter.
- clk  input  1  rising-edge clock; the block uses a single clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit k belongs to requester k.
- din  input  4*W  requester words; requester k occupies din[k*W+W-1 : k*W].
- gnt  output  4  one-hot grant, combinational; high in the cycle requester k's word is loaded.
- q  output  W  held register contents.
- q_valid  output  1  q holds an unconsumed word.
- q_src  output  2  index of the requester whose word is in q.
- q_ready  input  1  consumer accepts q in this cycle when q_valid=1.

## Operation
- State machine with two states:
  - EMPTY: q_valid=0.
  - FULL: q_valid=1.
- Load enable: load = (|req) && (state==EMPTY || q_ready).
- When load=1:
  - gnt has exactly one bit set, for the winner.
  - At the clock edge: q <= winner's din slice, q_src <= winner index, state <= FULL, last <= winner.
- Transitions:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on q_ready=1 with no req.
  - FULL -> FULL (back-to-back) on q_ready=1 with a load.
  - FULL with q_ready=0: hold q and q_src, gnt=0.
- Arbitration is round-robin over the 2-bit pointer `last`. Priority order is last+1, last+2, last+3, last, with indices modulo 4.
  - The pointer wraps 3 -> 0.
  - The pointer updates only on a load.
- When load=0, gnt=0 regardless of req.
- q_ready while q_valid=0 is ignored.
- Requester contract: hold req and its din slice stable until its gnt is seen. Drop req in the cycle after gnt unless it has another word to send.
- Reset values:
  - q=0, q_valid=0, q_src=0, gnt=0.
  - State EMPTY.
  - last=3, so requester 0 has top priority first.
- Reset mid-operation discards the held word, with no handshake.
- Reset takes priority over a simultaneous load or q_ready.
- Any W≥1 is valid. q and din slices are passed unmodified; no arithmetic on data.

## Timing
- gnt is asserted in cycle t, the same cycle as the qualifying req.
- q, q_src and q_valid reflect the load from edge t+1 onward.
- Latency from req to q_valid is 1 cycle.
- Throughput: one word per cycle when q_ready is held at 1 and requests are continuous.
- Simultaneous q_ready and load in FULL:
  - The old word is consumed and the new word is loaded at the same edge.
  - q_valid stays 1 with no bubble.
- With all four requesters held high and q_ready=1, grants rotate 0,1,2,3,0,... one per cycle.
- A requester waits at most 3 loads behind others, so there is no starvation.
- gnt is combinational from req, state, q_ready and last. No combinational path exists from req to q or q_valid.

## Test plan
- Reset: assert rst for 2 cycles with req=4'hF.
  - Required: q=0, q_valid=0, q_src=0 and gnt=0 throughout.
  - First grant after release goes to requester 0.
- Single load: req=4'b0100 with slice 2 =4'hA and q_ready=0.
  - Required: gnt=4'b0100 for one cycle; next cycle q=4'hA, q_src=2, q_valid=1.
  - Then gnt=0 and q is held while q_ready=0.
- Back-to-back rotation: req=4'hF, slices 1,2,3,4, q_ready=1 constant.
  - Required: gnt sequence 0001,0010,0100,1000,0001.
  - q sequence 1,2,3,4,1 on successive cycles.
  - q_valid never drops.
- Backpressure: fill q, then hold q_ready=0 for 5 cycles with req=4'b0011.
  - Required: gnt=0 and q unchanged for 5 cycles.
  - On q_ready=1, the next grant follows round-robin order from last.
- Drain: in FULL, q_ready=1 with req=0.
  - Required: q_valid=0 next cycle; q keeps its last value; later q_ready pulses have no effect.
- Reset mid-FULL: q=4'h5, q_valid=1, assert rst together with req=4'b1000 and q_ready=1.
  - Required: next cycle q=0, q_valid=0, last=3.
  - No load occurs.

Source files
------------

// File: rtl/pipo_share_ctrl.sv
// pipo_share_ctrl: round-robin sharing of one W-bit holding register among
// four requesters. A requester is granted when the register is empty, or when
// the consumer is draining it in the same cycle. The granted word is captured
// and held with a valid flag until the consumer accepts it.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester request, bit k = requester k
//   din      requester words, requester k at din[k*W +: W]
//   gnt      one-hot grant (combinational), high in the load cycle
//   q        held register contents
//   q_valid  q holds an unconsumed word
//   q_src    index of the requester whose word is in q
//   q_ready  consumer accepts q this cycle when q_valid=1
module pipo_share_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] din,
    output logic [3:0]     gnt,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [1:0]     q_src,
    input  logic           q_ready
);

    localparam int unsigned N = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      last;
    logic [1:0]      win_idx;
    logic            win_found;
    logic [1:0]      cand;
    logic            load;
    logic [W-1:0]    slice [N];

    // Unpack the flat requester bus into per-requester words
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            slice[k] = din[k*W +: W];
        end
    end

    // Round-robin pick: search last+1, last+2, last+3, then last itself
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        cand      = last;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = last + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and load/grant decode; reset suppresses any load in its cycle
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        gnt       = 4'b0000;
        case (state)
            EMPTY: begin
                if (win_found) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (q_ready) begin
                    if (win_found) begin
                        load      = 1'b1;
                        state_nxt = FULL;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (rst) begin
            load = 1'b0;
        end
        if (load) begin
            gnt = 4'b0001 << win_idx;
        end
    end

    // State, holding register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            q     <= '0;
            q_src <= 2'd0;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            if (load) begin
                q     <= slice[win_idx];
                q_src <= win_idx;
                last  <= win_idx;
            end
        end
    end

    assign q_valid = (state == FULL);

endmodule

// File: tb/tb_pipo_share_ctrl.sv
// Directed bench for pipo_share_ctrl. The driver applies per-cycle vectors and
// checks gnt and held state against hand-computed values; every word expected
// to reach the consumer is queued, and a monitor pops and compares on each
// consumer handshake.
module tb_pipo_share_ctrl;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [1:0]     q_src;
    logic           q_ready;

    typedef struct packed {
        logic [W-1:0] q;
        logic [1:0]   src;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    pipo_share_ctrl #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_src   (q_src),
        .q_ready (q_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Apply inputs; optionally queue the word expected to be loaded this cycle
    task automatic drive(input logic r, input logic [3:0] rq, input logic [15:0] d,
                         input logic qr, input logic push, input logic [3:0] eq,
                         input logic [1:0] es);
        exp_t e;
        rst     = r;
        req     = rq;
        din     = d;
        q_ready = qr;
        if (push) begin
            e.q   = eq;
            e.src = es;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hold(input string name, input logic [3:0] eq, input logic es,
                            input logic [1:0] esrc, input logic ev);
        chk({name, "_q"}, 32'(q), 32'(eq));
        chk({name, "_qv"}, 32'(q_valid), 32'(ev));
        if (es) chk({name, "_src"}, 32'(q_src), 32'(esrc));
    endtask

    // Monitor: every consumer handshake must match the oldest queued word
    always @(negedge clk) begin
        if (!rst && q_valid && q_ready) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_pop", 32'(q), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_q", 32'(q), 32'(e.q));
                chk("mon_src", 32'(q_src), 32'(e.src));
            end
        end
    end

    initial begin
        // Reset with all requests high: no grant, cleared outputs
        drive(1, 4'hF, 16'h4321, 0, 0, 0, 0);
        chk("rst0_gnt", 32'(gnt), 32'h0);
        chk_hold("rst0", 4'h0, 1, 2'd0, 0);
        next_cycle();
        drive(1, 4'hF, 16'h4321, 0, 0, 0, 0);
        chk("rst1_gnt", 32'(gnt), 32'h0);
        chk_hold("rst1", 4'h0, 1, 2'd0, 0);
        next_cycle();

        // Release: rotation 0,1,2,3,0 with q_ready held high
        drive(0, 4'hF, 16'h4321, 1, 1, 4'h1, 2'd0);
        chk("rot0_gnt", 32'(gnt), 32'b0001);
        chk_hold("rot0", 4'h0, 1, 2'd0, 0);
        next_cycle();
        drive(0, 4'hF, 16'h4321, 1, 1, 4'h2, 2'd1);
        chk("rot1_gnt", 32'(gnt), 32'b0010);
        chk_hold("rot1", 4'h1, 1, 2'd0, 1);
        next_cycle();
        drive(0, 4'hF, 16'h4321, 1, 1, 4'h3, 2'd2);
        chk("rot2_gnt", 32'(gnt), 32'b0100);
        chk_hold("rot2", 4'h2, 1, 2'd1, 1);
        next_cycle();
        drive(0, 4'hF, 16'h4321, 1, 1, 4'h4, 2'd3);
        chk("rot3_gnt", 32'(gnt), 32'b1000);
        chk_hold("rot3", 4'h3, 1, 2'd2, 1);
        next_cycle();
        drive(0, 4'hF, 16'h4321, 1, 1, 4'h1, 2'd0);
        chk("rot4_gnt", 32'(gnt), 32'b0001);
        chk_hold("rot4", 4'h4, 1, 2'd3, 1);
        next_cycle();

        // Drain the last rotated word
        drive(0, 4'h0, 16'h4321, 1, 0, 0, 0);
        chk("drain0_gnt", 32'(gnt), 32'h0);
        chk_hold("drain0", 4'h1, 1, 2'd0, 1);
        next_cycle();

        // Single load from requester 2 with backpressure
        drive(0, 4'b0100, 16'h4A21, 0, 1, 4'hA, 2'd2);
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk_hold("single_pre", 4'h1, 0, 2'd0, 0);
        next_cycle();
        drive(0, 4'h0, 16'h4A21, 0, 0, 0, 0);
        chk("single_hold_gnt", 32'(gnt), 32'h0);
        chk_hold("single_load", 4'hA, 1, 2'd2, 1);
        next_cycle();
        drive(0, 4'h0, 16'h4A21, 0, 0, 0, 0);
        chk_hold("single_held", 4'hA, 1, 2'd2, 1);
        next_cycle();

        // Backpressure: requesters 0,1 waiting while q_ready=0
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0011, 16'h4321, 0, 0, 0, 0);
            chk("bp_gnt", 32'(gnt), 32'h0);
            chk_hold("bp", 4'hA, 1, 2'd2, 1);
            next_cycle();
        end
        // Pointer at 2: order 3,0,1 -> requester 0, then 1
        drive(0, 4'b0011, 16'h4321, 1, 1, 4'h1, 2'd0);
        chk("bp_rel0_gnt", 32'(gnt), 32'b0001);
        next_cycle();
        drive(0, 4'b0011, 16'h4321, 1, 1, 4'h2, 2'd1);
        chk("bp_rel1_gnt", 32'(gnt), 32'b0010);
        next_cycle();

        // Drain, then stray q_ready pulses while empty
        drive(0, 4'h0, 16'h4321, 1, 0, 0, 0);
        chk("drain1_gnt", 32'(gnt), 32'h0);
        next_cycle();
        drive(0, 4'h0, 16'h4321, 1, 0, 0, 0);
        chk_hold("drained", 4'h2, 1, 2'd1, 0);
        next_cycle();
        drive(0, 4'h0, 16'h4321, 0, 0, 0, 0);
        chk_hold("idle0", 4'h2, 0, 2'd0, 0);
        next_cycle();
        drive(0, 4'h0, 16'h4321, 1, 0, 0, 0);
        chk_hold("idle1", 4'h2, 1, 2'd1, 0);
        next_cycle();

        // Fill with 5 from requester 2 (word is discarded by reset, not queued)
        drive(0, 4'b0100, 16'h4521, 0, 0, 0, 0);
        chk("fill5_gnt", 32'(gnt), 32'b0100);
        next_cycle();
        drive(0, 4'h0, 16'h4521, 0, 0, 0, 0);
        chk_hold("full5", 4'h5, 1, 2'd2, 1);
        next_cycle();

        // Reset mid-FULL with competing load and q_ready
        drive(1, 4'b1000, 16'h4521, 1, 0, 0, 0);
        chk("rstmid_gnt", 32'(gnt), 32'h0);
        next_cycle();
        drive(0, 4'h0, 16'h4521, 0, 0, 0, 0);
        chk_hold("rstmid", 4'h0, 1, 2'd0, 0);
        next_cycle();
        // Pointer back at 3: requester 0 wins over 3
        drive(0, 4'hF, 16'h4321, 0, 1, 4'h1, 2'd0);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        next_cycle();
        drive(0, 4'h0, 16'h4321, 1, 0, 0, 0);
        chk_hold("post_rst", 4'h1, 1, 2'd0, 1);
        next_cycle();
        drive(0, 4'h0, 16'h4321, 0, 0, 0, 0);
        chk("final_qv", 32'(q_valid), 32'h0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
